// File: rtl/hs32_mem_arbiter.sv
// Shares the HS32 SRAM between the Wishbone slave port and the core bus and sequences core reset.
// Optional write protection of the running core's memory: define HS32_ARB_WPROT_EN.
module hs32_mem_arbiter #(
    parameter int AW              = 8,
    parameter int CORE_RST_CYCLES = 4
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    input  logic          core_run_i,
    output logic          core_rst_o,
    input  logic          cpu_stb_i,
    input  logic          cpu_rw_i,
    input  logic [31:0]   cpu_addr_i,
    input  logic [31:0]   cpu_dat_i,
    output logic          cpu_ack_o,
    output logic [31:0]   cpu_dat_o,
    output logic          sram_ce_o,
    output logic          sram_we_o,
    output logic [3:0]    sram_wmask_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [31:0]   sram_din_o,
    input  logic [31:0]   sram_dout_i,
    output logic          wprot_err_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int            CW       = $clog2(CORE_RST_CYCLES + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(CORE_RST_CYCLES);

    logic [1:0]    state;
    logic          req_wb;
    logic          req_we;
    logic          req_blk;
    logic [3:0]    req_mask;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_data;
    logic          last_wb;
    logic [CW-1:0] run_cnt;
    logic          core_rst;
    logic [31:0]   wb_rdata;
    logic [31:0]   cpu_rdata;

    logic wb_req;
    logic cpu_req;
    logic grant_wb;
    logic grant_any;
    logic blk_next;
    logic wb_rd_resp;
    logic cpu_resp_ok;
    logic unused_addr_bits;

    assign wb_req    = wbs_stb_i & wbs_cyc_i;
    assign cpu_req   = cpu_stb_i & ~core_rst;
    // On contention the requester that lost last time gets the slot.
    assign grant_wb  = wb_req & (~cpu_req | ~last_wb);
    assign grant_any = wb_req | cpu_req;

`ifdef HS32_ARB_WPROT_EN
    logic wprot_err;

    assign blk_next = grant_wb & wbs_we_i & ~core_rst;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            wprot_err <= 1'b0;
        else if (state == S_IDLE && blk_next)
            wprot_err <= 1'b1;
    end

    assign wprot_err_o = wprot_err;
`else
    assign blk_next    = 1'b0;
    assign wprot_err_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= S_IDLE;
            req_wb   <= 1'b0;
            req_we   <= 1'b0;
            req_blk  <= 1'b0;
            req_mask <= 4'h0;
            req_addr <= '0;
            req_data <= 32'h0;
            last_wb  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        state   <= S_ACC;
                        req_wb  <= grant_wb;
                        last_wb <= grant_wb;
                        req_blk <= blk_next;
                        if (grant_wb) begin
                            req_we   <= wbs_we_i;
                            req_mask <= wbs_sel_i;
                            req_addr <= wbs_adr_i[AW+1:2];
                            req_data <= wbs_dat_i;
                        end else begin
                            req_we   <= cpu_rw_i;
                            req_mask <= 4'hF;
                            req_addr <= cpu_addr_i[AW+1:2];
                            req_data <= cpu_dat_i;
                        end
                    end
                end
                S_ACC:   state <= S_RESP;
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // The core is held in reset until run has been high for CORE_RST_CYCLES edges.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !core_run_i) begin
            run_cnt  <= '0;
            core_rst <= 1'b1;
        end else if (run_cnt != CNT_DONE) begin
            run_cnt <= run_cnt + CW'(1);
            if (run_cnt + CW'(1) == CNT_DONE)
                core_rst <= 1'b0;
        end
    end

    assign wb_rd_resp  = (state == S_RESP) & req_wb & ~req_we;
    assign cpu_resp_ok = (state == S_RESP) & ~req_wb & ~core_rst;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_rdata  <= 32'h0;
            cpu_rdata <= 32'h0;
        end else begin
            if (wb_rd_resp)
                wb_rdata <= sram_dout_i;
            if (cpu_resp_ok && !req_we)
                cpu_rdata <= sram_dout_i;
        end
    end

    // Read data is forwarded straight from the SRAM during RESP, then held.
    assign wbs_ack_o = (state == S_RESP) & req_wb & wbs_cyc_i & ~wb_rst_i;
    assign cpu_ack_o = cpu_resp_ok & ~wb_rst_i;
    assign wbs_dat_o = wb_rd_resp ? sram_dout_i : wb_rdata;
    assign cpu_dat_o = (cpu_resp_ok && !req_we) ? sram_dout_i : cpu_rdata;

    assign core_rst_o   = core_rst;
    assign sram_ce_o    = (state == S_ACC);
    assign sram_we_o    = sram_ce_o & req_we & ~req_blk;
    assign sram_wmask_o = sram_we_o ? req_mask : 4'h0;
    assign sram_addr_o  = req_addr;
    assign sram_din_o   = req_data;

    assign unused_addr_bits = ^{wbs_adr_i[31:AW+2], wbs_adr_i[1:0],
                                cpu_addr_i[31:AW+2], cpu_addr_i[1:0]};

endmodule
